// File: rtl/conv_pkg.sv
// Shared types and helpers for the row-streaming 3x3 convolution engine.
package conv_pkg;

  // Sequencer states: issue reads, push the bottom padding row, pulse done.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Taps in a 3x3 window.
  localparam int TAPS = 9;

  // Signed accumulator width: product of zero-extended pixel and signed
  // weight is DW+KW+1 bits, nine of them need four more bits of headroom.
  function automatic int acc_w(input int dw, input int kw);
    return dw + kw + 5;
  endfunction

  // Flat index of weight/pixel (i, j); i is the row (0 = top), j the column.
  function automatic int k_idx(input int i, input int j);
    return 3 * i + j;
  endfunction

  // Largest unsigned value of a dw-bit pixel, the upper saturation bound.
  function automatic int unsigned sat_max(input int dw);
    return (32'd1 << dw) - 32'd1;
  endfunction

endpackage

// File: rtl/conv_pe.sv
// One output pixel: 3x3 multiply-accumulate, arithmetic right shift and
// unsigned saturation. Purely combinational.
module conv_pe
  import conv_pkg::*;
#(
  parameter int DW = 8,
  parameter int KW = 8
) (
  input  logic [TAPS*DW-1:0] pix,
  input  logic [TAPS*KW-1:0] wts,
  input  logic [4:0]         shift,
  output logic [DW-1:0]      result
);

  localparam int ACC = acc_w(DW, KW);
  localparam logic signed [ACC-1:0] MAX_V = ACC'(sat_max(DW));

  logic signed [ACC-1:0] acc;
  logic signed [ACC-1:0] w_ext;
  logic signed [ACC-1:0] p_ext;
  logic signed [ACC-1:0] shifted;

  // Sum the nine products, shift, then clamp into the unsigned pixel range.
  always_comb begin
    acc   = '0;
    w_ext = '0;
    p_ext = '0;
    for (int k = 0; k < TAPS; k++) begin
      w_ext = {{(ACC-KW){wts[KW*k+KW-1]}}, wts[KW*k +: KW]};
      p_ext = {{(ACC-DW){1'b0}}, pix[DW*k +: DW]};
      acc   = acc + w_ext * p_ext;
    end
    shifted = acc >>> shift;
    if (shifted[ACC-1]) begin
      result = '0;
    end else if (shifted > MAX_V) begin
      result = '1;
    end else begin
      result = shifted[DW-1:0];
    end
  end

endmodule

// File: rtl/conv_row_engine.sv
// Row-streaming 3x3 convolution engine: reads rows from the input RAM,
// slides a zero-padded three-row window and writes one result row per cycle.
module conv_row_engine
  import conv_pkg::*;
#(
  parameter int PIX  = 128,
  parameter int DW   = 8,
  parameter int KW   = 8,
  parameter int ROWS = 256,
  parameter int AW   = $clog2(ROWS)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               conv_run,
  input  logic [TAPS*KW-1:0] kernel,
  input  logic [4:0]         shift,
  output logic               rd_en,
  output logic [AW-1:0]      rd_addr,
  input  logic [PIX*DW-1:0]  rd_data,
  output logic               wr_en,
  output logic [AW-1:0]      wr_addr,
  output logic [PIX*DW-1:0]  wr_data,
  output logic               busy,
  output logic               conv_done
);

  state_e              state_q, state_d;
  logic [AW-1:0]       rd_cnt_q, rd_cnt_d;
  logic [AW-1:0]       wr_cnt_q, wr_cnt_d;
  logic [TAPS*KW-1:0]  kern_q, kern_d;
  logic [4:0]          shift_q, shift_d;
  logic [PIX*DW-1:0]   top_q, top_d;
  logic [PIX*DW-1:0]   mid_q, mid_d;
  logic [PIX*DW-1:0]   bot_q, bot_d;
  // dv: RAM data valid this cycle; fl: zero padding row due next edge;
  // sh1/sh2: window shifted one / two edges ago.
  logic                dv_q, dv_d;
  logic                fl_q, fl_d;
  logic                sh1_q, sh1_d;
  logic                sh2_q, sh2_d;
  logic                rd_en_q, rd_en_d;
  logic [AW-1:0]       rd_addr_q, rd_addr_d;
  logic                wr_en_q, wr_en_d;
  logic [AW-1:0]       wr_addr_q, wr_addr_d;
  logic [PIX*DW-1:0]   wr_data_q, wr_data_d;
  logic                busy_q, busy_d;
  logic                conv_done_q, conv_done_d;

  logic                shift_en;
  logic                write_now;
  logic [PIX*DW-1:0]   pe_row;
  logic [PIX*DW-1:0]   win_row [3];

  assign win_row[0] = top_q;
  assign win_row[1] = mid_q;
  assign win_row[2] = bot_q;

  // One processing element per column; taps outside the row read as zero.
  for (genvar gi = 0; gi < PIX; gi++) begin : g_pix
    logic [TAPS*DW-1:0] taps;
    for (genvar gr = 0; gr < 3; gr++) begin : g_r
      for (genvar gc = 0; gc < 3; gc++) begin : g_c
        if ((gi + gc - 1 < 0) || (gi + gc - 1 >= PIX)) begin : g_pad
          assign taps[DW*k_idx(gr, gc) +: DW] = '0;
        end else begin : g_tap
          assign taps[DW*k_idx(gr, gc) +: DW] = win_row[gr][DW*(gi+gc-1) +: DW];
        end
      end
    end
    conv_pe #(
      .DW (DW),
      .KW (KW)
    ) u_pe (
      .pix    (taps),
      .wts    (kern_q),
      .shift  (shift_q),
      .result (pe_row[DW*gi +: DW])
    );
  end

  // Next-state logic: sequencer, read/write counters, window and outputs.
  always_comb begin
    state_d     = state_q;
    rd_cnt_d    = rd_cnt_q;
    wr_cnt_d    = wr_cnt_q;
    kern_d      = kern_q;
    shift_d     = shift_q;
    top_d       = top_q;
    mid_d       = mid_q;
    bot_d       = bot_q;
    rd_en_d     = 1'b0;
    rd_addr_d   = '0;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    conv_done_d = 1'b0;

    // Read pipeline: data arrives the cycle after rd_en; the padding row
    // follows the last data row.
    dv_d     = rd_en_q;
    fl_d     = dv_q & ~rd_en_q;
    shift_en = dv_q | fl_q;
    sh1_d    = shift_en;
    sh2_d    = sh1_q;

    if (shift_en) begin
      top_d = mid_q;
      mid_d = bot_q;
      bot_d = dv_q ? rd_data : '0;
    end

    // The first shift only loads bot; every later shift completes a window.
    write_now = sh1_q & sh2_q;
    if (write_now) begin
      wr_en_d   = 1'b1;
      wr_addr_d = wr_cnt_q;
      wr_data_d = pe_row;
      wr_cnt_d  = wr_cnt_q + AW'(1);
    end

    unique case (state_q)
      IDLE: begin
        if (conv_run) begin
          state_d  = RUN;
          kern_d   = kernel;
          shift_d  = shift;
          top_d    = '0;
          mid_d    = '0;
          bot_d    = '0;
          rd_cnt_d = '0;
          wr_cnt_d = '0;
          dv_d     = 1'b0;
          fl_d     = 1'b0;
          sh1_d    = 1'b0;
          sh2_d    = 1'b0;
        end
      end
      RUN: begin
        rd_en_d   = 1'b1;
        rd_addr_d = rd_cnt_q;
        rd_cnt_d  = rd_cnt_q + AW'(1);
        if (rd_cnt_q == AW'(ROWS - 1)) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (write_now && (wr_cnt_q == AW'(ROWS - 1))) begin
          state_d = DONE;
        end
      end
      DONE: begin
        conv_done_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Low in the accept cycle and in the done cycle.
    busy_d = (state_q != IDLE) && (state_d != IDLE);
  end

  // State and datapath registers; reset aborts any run without a done pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      rd_cnt_q    <= '0;
      wr_cnt_q    <= '0;
      kern_q      <= '0;
      shift_q     <= '0;
      top_q       <= '0;
      mid_q       <= '0;
      bot_q       <= '0;
      dv_q        <= 1'b0;
      fl_q        <= 1'b0;
      sh1_q       <= 1'b0;
      sh2_q       <= 1'b0;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      busy_q      <= 1'b0;
      conv_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_cnt_q    <= rd_cnt_d;
      wr_cnt_q    <= wr_cnt_d;
      kern_q      <= kern_d;
      shift_q     <= shift_d;
      top_q       <= top_d;
      mid_q       <= mid_d;
      bot_q       <= bot_d;
      dv_q        <= dv_d;
      fl_q        <= fl_d;
      sh1_q       <= sh1_d;
      sh2_q       <= sh2_d;
      rd_en_q     <= rd_en_d;
      rd_addr_q   <= rd_addr_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      busy_q      <= busy_d;
      conv_done_q <= conv_done_d;
    end
  end

  assign rd_en     = rd_en_q;
  assign rd_addr   = rd_addr_q;
  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign busy      = busy_q;
  assign conv_done = conv_done_q;

endmodule

// File: tb/tb_conv_row_engine.sv
// Directed bench: full-size engine (128 x 256) plus a 4 x 2 configuration.
module tb_conv_row_engine;

  localparam int DW  = 8;
  localparam int KW  = 8;
  localparam int PA  = 128;
  localparam int RA  = 256;
  localparam int AWA = 8;
  localparam int PB  = 4;
  localparam int RB  = 2;
  localparam int AWB = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  logic               run_a, rd_en_a, wr_en_a, busy_a, done_a;
  logic [9*KW-1:0]    kern_a;
  logic [4:0]         sh_a;
  logic [AWA-1:0]     rd_addr_a, wr_addr_a;
  logic [PA*DW-1:0]   rd_data_a, wr_data_a;
  logic [PA*DW-1:0]   iram_a [RA];
  logic [PA*DW-1:0]   oram_a [RA];

  logic               run_b, rd_en_b, wr_en_b, busy_b, done_b;
  logic [9*KW-1:0]    kern_b;
  logic [4:0]         sh_b;
  logic [AWB-1:0]     rd_addr_b, wr_addr_b;
  logic [PB*DW-1:0]   rd_data_b, wr_data_b;
  logic [PB*DW-1:0]   iram_b [RB];
  logic [PB*DW-1:0]   oram_b [RB];

  int n_checks = 0;
  int n_errors = 0;

  int exp_b1 [8] = '{22, 29, 36, 34, 3, 14, 17, 25};
  int exp_b2 [8] = '{120, 30, 0, 0, 255, 255, 255, 255};

  conv_row_engine #(.PIX(PA), .DW(DW), .KW(KW), .ROWS(RA)) u_dut_a (
    .clk(clk), .reset(reset), .conv_run(run_a), .kernel(kern_a), .shift(sh_a),
    .rd_en(rd_en_a), .rd_addr(rd_addr_a), .rd_data(rd_data_a),
    .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a),
    .busy(busy_a), .conv_done(done_a)
  );

  conv_row_engine #(.PIX(PB), .DW(DW), .KW(KW), .ROWS(RB)) u_dut_b (
    .clk(clk), .reset(reset), .conv_run(run_b), .kernel(kern_b), .shift(sh_b),
    .rd_en(rd_en_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b),
    .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b),
    .busy(busy_b), .conv_done(done_b)
  );

  // Block RAM models: one-cycle read latency, write on wr_en.
  always @(posedge clk) begin
    if (rd_en_a) rd_data_a <= iram_a[rd_addr_a];
    if (wr_en_a) oram_a[wr_addr_a] <= wr_data_a;
    if (rd_en_b) rd_data_b <= iram_b[rd_addr_b];
    if (wr_en_b) oram_b[wr_addr_b] <= wr_data_b;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [71:0] mk_k(input int a0, a1, a2, a3, a4, a5, a6, a7, a8);
    logic [71:0] k;
    k = {8'(a8), 8'(a7), 8'(a6), 8'(a5), 8'(a4), 8'(a3), 8'(a2), 8'(a1), 8'(a0)};
    return k;
  endfunction

  // Expected control outputs n cycles after the accept edge.
  task automatic chk_cycle(input string dut, input int rows, input int n,
                           input logic rd_en, input int rd_addr,
                           input logic wr_en, input int wr_addr,
                           input logic busy, input logic done);
    logic [3:0] exp_f;
    exp_f = {(n >= 1 && n <= rows), (n >= 5 && n <= rows + 4),
             (n >= 1 && n <= rows + 4), (n == rows + 5)};
    check_eq($sformatf("%s c%0d rd/wr/busy/done", dut, n), {rd_en, wr_en, busy, done}, exp_f);
    if (rd_en) check_eq($sformatf("%s c%0d rd_addr", dut, n), rd_addr, n - 1);
    if (wr_en) check_eq($sformatf("%s c%0d wr_addr", dut, n), wr_addr, n - 5);
  endtask

  // Full-size run; with pulse set, conv_run and a different kernel/shift
  // are presented mid-run and must be ignored.
  task automatic run_a_task(input string name, input logic [71:0] k, input logic [4:0] s, input bit pulse);
    kern_a = k;
    sh_a   = s;
    run_a  = 1'b1;
    @(posedge clk);
    #1;
    run_a = 1'b0;
    for (int n = 0; n <= RA + 5; n++) begin
      if (n > 0) begin
        @(posedge clk);
        #1;
      end
      chk_cycle("A", RA, n, rd_en_a, int'(rd_addr_a), wr_en_a, int'(wr_addr_a), busy_a, done_a);
      if (pulse && (n == 3 || n == 100)) begin
        run_a  = 1'b1;
        kern_a = mk_k(-1, 2, -1, 2, 5, 2, -1, 2, -1);
        sh_a   = 5'd1;
      end else begin
        run_a = 1'b0;
      end
    end
    $display("run %s: %0d rows, done expected at cycle %0d", name, RA, RA + 5);
  endtask

  task automatic run_b_task(input string name, input logic [71:0] k, input logic [4:0] s);
    kern_b = k;
    sh_b   = s;
    run_b  = 1'b1;
    @(posedge clk);
    #1;
    run_b = 1'b0;
    for (int n = 0; n <= RB + 5; n++) begin
      if (n > 0) begin
        @(posedge clk);
        #1;
      end
      chk_cycle("B", RB, n, rd_en_b, int'(rd_addr_b), wr_en_b, int'(wr_addr_b), busy_b, done_b);
    end
    $display("run %s: %0d rows, done expected at cycle %0d", name, RB, RB + 5);
  endtask

  task automatic fill_a_const(input logic [7:0] v);
    for (int r = 0; r < RA; r++) iram_a[r] = {PA{v}};
  endtask

  // mode 0: output equals input; mode 1: interior/border/corner constants.
  task automatic chk_img_a(input string name, input int mode, input int vi, input int ve, input int vc);
    int e;
    int expv;
    for (int r = 0; r < RA; r++) begin
      for (int c = 0; c < PA; c++) begin
        e = ((r == 0 || r == RA - 1) ? 1 : 0) + ((c == 0 || c == PA - 1) ? 1 : 0);
        expv = (e == 0) ? vi : ((e == 1) ? ve : vc);
        if (mode == 0) expv = int'(iram_a[r][DW*c +: DW]);
        check_eq($sformatf("%s r%0d c%0d", name, r, c), oram_a[r][DW*c +: DW], expv);
      end
    end
  endtask

  task automatic chk_img_b(input string name, input int e [8]);
    for (int r = 0; r < RB; r++) begin
      for (int c = 0; c < PB; c++) begin
        check_eq($sformatf("%s r%0d c%0d", name, r, c), oram_b[r][DW*c +: DW], e[r*PB + c]);
      end
    end
  endtask

  initial begin
    int seen;
    logic [71:0] k_ones;
    k_ones = mk_k(1, 1, 1, 1, 1, 1, 1, 1, 1);
    reset  = 1'b0;
    run_a  = 1'b0;
    run_b  = 1'b0;
    kern_a = '0;
    kern_b = '0;
    sh_a   = '0;
    sh_b   = '0;

    // Reset state, under reset and after release.
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset A outs", {rd_en_a, rd_addr_a, wr_en_a, wr_addr_a, busy_a, done_a}, 0);
    check_eq("reset A wr_data", 64'(wr_data_a != '0), 0);
    check_eq("reset B outs", {rd_en_b, rd_addr_b, wr_en_b, wr_addr_b, busy_b, done_b, wr_data_b}, 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("idle A outs", {rd_en_a, wr_en_a, busy_a, done_a}, 0);

    // Identity kernel on a random image reproduces the image.
    for (int r = 0; r < RA; r++)
      for (int c = 0; c < PA; c++)
        iram_a[r][DW*c +: DW] = 8'($urandom);
    run_a_task("identity", mk_k(0, 0, 0, 0, 1, 0, 0, 0, 0), 5'd0, 1'b0);
    chk_img_a("ident", 0, 0, 0, 0);

    // All-ones kernel on a flat image, with ignored mid-run requests,
    // then a back-to-back run with shift 3.
    fill_a_const(8'd10);
    run_a_task("ones_s0_pulsed", k_ones, 5'd0, 1'b1);
    chk_img_a("ones_s0", 1, 90, 60, 40);
    run_a_task("ones_s3_b2b", k_ones, 5'd3, 1'b0);
    chk_img_a("ones_s3", 1, 11, 7, 5);

    // Negative sums clamp to zero; large sums clamp to 255.
    run_a_task("neg", mk_k(-1, -1, -1, -1, -1, -1, -1, -1, -1), 5'd0, 1'b0);
    chk_img_a("neg", 1, 0, 0, 0);
    fill_a_const(8'd255);
    run_a_task("sat", k_ones, 5'd0, 1'b0);
    chk_img_a("sat", 1, 255, 255, 255);

    // Abort a run with reset in cycle 50.
    fill_a_const(8'd10);
    kern_a = k_ones;
    sh_a   = 5'd0;
    run_a  = 1'b1;
    @(posedge clk);
    #1;
    run_a = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    check_eq("pre-abort rd_en/wr_en", {rd_en_a, wr_en_a}, 2'b11);
    reset = 1'b0;
    #1;
    check_eq("abort outs", {rd_en_a, rd_addr_a, wr_en_a, wr_addr_a, busy_a, done_a}, 0);
    check_eq("abort wr_data", 64'(wr_data_a != '0), 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    seen = 0;
    repeat (RA + 10) begin
      @(posedge clk);
      #1;
      if (done_a || busy_a) seen++;
    end
    check_eq("abort no done/busy", seen, 0);
    run_a_task("after_abort", k_ones, 5'd3, 1'b0);
    chk_img_a("after_abort", 1, 11, 7, 5);

    // Small configuration, both rows padded above and below.
    iram_b[0] = {8'd4, 8'd3, 8'd2, 8'd1};
    iram_b[1] = {8'd8, 8'd7, 8'd6, 8'd5};
    run_b_task("small_mixed", mk_k(1, 0, -1, 2, 1, 0, 0, 3, 1), 5'd0);
    chk_img_b("small_mixed", exp_b1);
    iram_b[0] = {8'd200, 8'd200, 8'd200, 8'd200};
    iram_b[1] = {8'd40, 8'd30, 8'd20, 8'd10};
    run_b_task("small_clamp", mk_k(0, 2, 0, 0, 1, 0, -1, -8, 0), 5'd0);
    chk_img_b("small_clamp", exp_b2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
